// File: rtl/mips_muldiv_seq_pkg.sv
// Shared ALU opcode constants and multiply/divide sequencer state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mips_muldiv_seq_pkg;

  localparam logic [3:0] OP_MULTU = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Counter value seen on the 32nd iteration edge.
  localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/mips_divu_step.sv
// One radix-2 restoring-division step: shift in a dividend bit, trial-subtract.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_i partial remainder, dvd_bit_i next dividend bit, divisor_i divisor;
//        rem_o next partial remainder, q_bit_o quotient bit produced by this step.
module mips_divu_step (
  input  logic [31:0] rem_i,
  input  logic        dvd_bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  logic [33:0] shifted;
  logic [33:0] diff;

  assign shifted = {1'b0, rem_i, dvd_bit_i};
  assign diff    = shifted - {2'b00, divisor_i};

  // No borrow means the divisor fits: keep the difference, quotient bit is 1.
  // Because rem_i < divisor_i, the kept remainder always fits in 32 bits.
  assign q_bit_o = ~diff[33];
  assign rem_o   = q_bit_o ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/mips_muldiv_seq.sv
// Sequential unsigned MULTU/DIVU unit, one radix-2 iteration per clock.
// Latency: 32 cycles Busy, then a one-cycle Done; DIVU by zero finishes in one cycle.
// Backpressure: Start is dropped unless idle/done; Busy stalls the pipeline; Flush cancels.
// Ports: LOGISIM_CLOCK_TREE_0[4] clock, RST_N async reset, Start/AluOP/X/Y request,
//        Flush cancel; Busy, Done, HI, LO, DivZero results/status.
module mips_muldiv_seq
  import mips_muldiv_seq_pkg::*;
(
  input  logic [4:0]  LOGISIM_CLOCK_TREE_0,
  input  logic        RST_N,
  input  logic        Start,
  input  logic [3:0]  AluOP,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        DivZero
);

  logic       clk;
  logic [3:0] unused_clk_bits;

  assign clk             = LOGISIM_CLOCK_TREE_0[4];
  assign unused_clk_bits = LOGISIM_CLOCK_TREE_0[3:0];

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
  logic [63:0] acc_q, acc_d;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        divz_q, divz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        op_ok;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [31:0] div_rem;
  logic        div_qbit;
  logic [63:0] div_next;

  // Shift-add: add the multiplicand into the upper half when the multiplier
  // LSB is set, then shift the whole 65-bit result right by one.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  mips_divu_step u_divu_step (
    .rem_i     (acc_q[63:32]),
    .dvd_bit_i (acc_q[31]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .q_bit_o   (div_qbit)
  );

  // Quotient bits shift in from the right as dividend bits leave on the left.
  assign div_next = {div_rem, acc_q[30:0], div_qbit};

  assign op_ok  = (AluOP == OP_MULTU) || (AluOP == OP_DIVU);
  assign accept = Start && op_ok && !Flush &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    divz_d  = divz_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          cnt_d  = 5'd0;
          divz_d = 1'b0;
          if (AluOP == OP_MULTU) begin
            opnd_d  = X;
            acc_d   = {32'd0, Y};
            state_d = ST_MUL;
          end else if (Y == 32'd0) begin
            // Divide by zero: flag it and finish without iterating.
            divz_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            opnd_d  = Y;
            acc_d   = {32'd0, X};
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == ITER_LAST) begin
            hi_d    = mul_next[63:32];
            lo_d    = mul_next[31:0];
            state_d = ST_DONE;
          end
        end
      end
      ST_DIV: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == ITER_LAST) begin
            hi_d    = div_next[63:32];
            lo_d    = div_next[31:0];
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      opnd_q  <= 32'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      divz_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      divz_q  <= divz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign DivZero = divz_q;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Directed bench for the sequential MULTU/DIVU unit.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mips_muldiv_seq;

  logic [4:0]  clk_tree;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  localparam logic [3:0] MULTU = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;

  mips_muldiv_seq dut (
    .LOGISIM_CLOCK_TREE_0 (clk_tree),
    .RST_N                (rst_n),
    .Start                (start),
    .AluOP                (alu_op),
    .X                    (x_in),
    .Y                    (y_in),
    .Flush                (flush),
    .Busy                 (busy),
    .Done                 (done),
    .HI                   (hi),
    .LO                   (lo),
    .DivZero              (div_zero)
  );

  initial clk_tree = 5'd0;
  always #5 clk_tree[4] = ~clk_tree[4];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge. Issues one request, waits (bounded) for Done and
  // checks latency, Busy duration, results and the single-cycle Done pulse.
  // inject_at >= 0 raises a MULTU Start while the operation is in flight.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat, input int inject_at);
    int cyc;
    int bcnt;
    alu_op = op;
    x_in   = x;
    y_in   = y;
    start  = 1'b1;
    @(negedge clk_tree[4]);
    start = 1'b0;
    cyc   = 0;
    bcnt  = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      if (cyc == inject_at) begin
        start  = 1'b1;
        alu_op = MULTU;
        x_in   = 32'd1;
        y_in   = 32'd1;
      end
      @(negedge clk_tree[4]);
      start = 1'b0;
      cyc++;
    end
    chk({tag, " latency"}, cyc, elat);
    chk({tag, " busy_cycles"}, bcnt, elat);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " divzero"}, {31'd0, div_zero}, {31'd0, edz});
    @(negedge clk_tree[4]);
    chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    alu_op = 4'd0;
    x_in   = 32'd0;
    y_in   = 32'd0;
    flush  = 1'b0;

    vecs[0] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32};
    vecs[1] = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32};
    vecs[2] = '{DIVU,  32'd5,        32'd9,        32'd5,        32'd0,        1'b0, 32};
    vecs[3] = '{DIVU,  32'h1234,     32'd0,        32'd5,        32'd0,        1'b1, 0};
    vecs[4] = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 32};
    vecs[5] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 32};
    vecs[6] = '{DIVU,  32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 1'b0, 32};
    vecs[7] = '{MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 32};

    // Reset state, before any clock edge.
    #2;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset divzero", {31'd0, div_zero}, 32'd0);
    @(negedge clk_tree[4]);
    rst_n = 1'b1;
    @(negedge clk_tree[4]);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y,
             vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat, -1);
    end

    // Flush after 10 iterations of MULTU 3*5.
    alu_op = MULTU;
    x_in   = 32'd3;
    y_in   = 32'd5;
    start  = 1'b1;
    @(negedge clk_tree[4]);
    start = 1'b0;
    chk("flush busy_before", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk_tree[4]);
    flush = 1'b1;
    @(negedge clk_tree[4]);
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    chk("flush hi", hi, prev_hi);
    chk("flush lo", lo, prev_lo);
    chk("flush divzero", {31'd0, div_zero}, 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done || busy) seen++;
        @(negedge clk_tree[4]);
      end
      chk("flush no_done", seen, 32'd0);
    end
    run_op("post_flush", MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 32, -1);

    // Flush and Start together: no accept.
    alu_op = MULTU;
    x_in   = 32'd2;
    y_in   = 32'd2;
    start  = 1'b1;
    flush  = 1'b1;
    @(negedge clk_tree[4]);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start busy", {31'd0, busy}, 32'd0);
    chk("flush_start done", {31'd0, done}, 32'd0);

    // Unsupported opcode in IDLE is ignored.
    alu_op = 4'd5;
    x_in   = 32'd9;
    y_in   = 32'd9;
    start  = 1'b1;
    @(negedge clk_tree[4]);
    start = 1'b0;
    chk("bad_op busy", {31'd0, busy}, 32'd0);
    chk("bad_op done", {31'd0, done}, 32'd0);
    chk("bad_op hi", hi, prev_hi);

    // Start during Busy is ignored; the in-flight result is still correct.
    run_op("start_in_busy", MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 32, 5);

    // Asynchronous reset at iteration 20.
    alu_op = MULTU;
    x_in   = 32'hFFFFFFFF;
    y_in   = 32'hFFFFFFFF;
    start  = 1'b1;
    @(negedge clk_tree[4]);
    start = 1'b0;
    repeat (20) @(negedge clk_tree[4]);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    chk("midreset divzero", {31'd0, div_zero}, 32'd0);
    @(negedge clk_tree[4]);
    rst_n = 1'b1;
    run_op("after_reset", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_seq.md
MIPS_MULDIV_SEQ -- requirements
Module: mips_muldiv_seq

Interface
REQ-001 SHALL have port LOGISIM_CLOCK_TREE_0  in  5  clock tree; bit [4] is the single rising-edge clock; bits [3:0] unused.
REQ-002 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port Start  in  1  request to begin an operation.
REQ-004 SHALL have port AluOP  in  4  opcode; 3 = MULTU, 4 = DIVU, other values are not accepted.
REQ-005 SHALL have port X  in  32  multiplicand or dividend, unsigned.
REQ-006 SHALL have port Y  in  32  multiplier or divisor, unsigned.
REQ-007 SHALL have port Flush  in  1  pipeline redirect; cancels any in-flight operation.
REQ-008 SHALL have port Busy  out  1  operation iterating; the pipeline stalls on it.
REQ-009 SHALL have port Done  out  1  one-cycle pulse; HI and LO are valid.
REQ-010 SHALL have port HI  out  32  high product word or remainder.
REQ-011 SHALL have port LO  out  32  low product word or quotient.
REQ-012 SHALL have port DivZero  out  1  last accepted DIVU had Y = 0; holds until the next accept.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV and DONE.
REQ-014 SHALL accept when Start=1, AluOP is 3 or 4, Flush=0 and state is IDLE or DONE; on accept, latch X and Y, clear the iteration counter and clear DivZero.
REQ-015 SHALL ignore Start with any other AluOP value, and SHALL ignore Start in MUL or DIV.
REQ-016 SHALL go to MUL on an accepted MULTU, and to DIV on an accepted DIVU with Y != 0.
REQ-017 SHALL perform one iteration per clock on each of the 32 edges after accept; MUL uses radix-2 shift-add over a 64-bit accumulator; DIV uses radix-2 restoring division.
REQ-018 SHALL, on the 32nd iteration edge, write HI/LO and enter DONE: MULTU gives HI = product[63:32], LO = product[31:0]; DIVU gives LO = quotient, HI = remainder.
REQ-019 SHALL hold Busy=1 exactly while in MUL or DIV, i.e. 32 cycles per operation.
REQ-020 SHALL hold Done=1 exactly while in DONE (one cycle); DONE then goes to IDLE, or to MUL/DIV on an accept.
REQ-021 SHALL handle an accepted DIVU with Y = 0 by setting DivZero=1, going directly to DONE, never asserting Busy, and leaving HI and LO unchanged.
REQ-022 SHALL, on Flush=1 in MUL or DIV, go to IDLE on the next edge with HI, LO and DivZero unchanged and no Done pulse.
REQ-023 SHALL give Flush priority over Start when both are high in the same cycle, so no accept occurs.
REQ-024 SHALL keep HI and LO stable at all times except on the REQ-018 write edge.
REQ-025 SHALL compute all arithmetic unsigned, with no overflow or exception outputs.

Reset
REQ-026 SHALL, with RST_N=0, immediately and without a clock force state to IDLE, HI=0, LO=0, Busy=0, Done=0, DivZero=0 and counter=0, including mid-operation.
REQ-027 SHALL, after reset, honour the first Start on the first rising edge at which RST_N=1.

Structure
REQ-028 SHALL take the opcode constants OP_MULTU=3 and OP_DIVU=4 from the shared ALU opcode definitions package, together with the 2-bit state encoding.
REQ-029 SHALL implement the combinational restoring-division step (partial remainder, divisor -> next remainder, quotient bit) as sub-module mips_divu_step.
REQ-030 SHALL contain no other sub-modules; the multiplier step SHALL be inline.

Verification
REQ-031 SHALL test MULTU with X=0xFFFFFFFF, Y=0xFFFFFFFF -> Busy for 32 cycles, then Done 32 cycles after accept, HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 SHALL test DIVU with X=100, Y=7 -> LO=14, HI=2, DivZero=0; then DIVU with X=5, Y=9 -> LO=0, HI=5.
REQ-033 SHALL test DIVU with X=0x1234, Y=0 -> Done one cycle after accept, Busy never high, DivZero=1, HI/LO equal to their prior values.
REQ-034 SHALL test MULTU with X=3, Y=5 and Flush after 10 iterations -> IDLE next edge, no Done, HI/LO unchanged; a following MULTU gives LO=15, HI=0.
REQ-035 SHALL test RST_N pulled low at iteration 20 -> all outputs 0 with no clock edge; a Start after release completes normally.
REQ-036 SHALL test Start with AluOP=5 in IDLE, and Start with AluOP=3 during Busy -> both ignored and the in-flight result is correct.
